// File: rtl/usb_transmitter.sv
// usb_transmitter: USB full-speed packet transmitter.
// Serializes SYNC (0x80), PID ({~pid,pid}) and FIFO payload bytes LSB first,
// applies bit stuffing (stuffed 0 after six 1s) and NRZI encoding, then
// terminates the packet with SE0, SE0, J.
// Optional feature macro: USB_TX_CRC16_EN appends the inverted CRC16 of the
// payload for DATAx PIDs (tx_pid[1:0] == 2'b11).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   tx_start        - one-cycle send request (sampled only in IDLE)
//   tx_pid[3:0]     - PID, latched on an accepted tx_start
//   tx_fifo_data    - FWFT head byte of TX FIFO
//   tx_fifo_empty   - TX FIFO empty flag
//   get_tx_data     - one-cycle FIFO pop strobe
//   dplus_out       - D+ line drive
//   dminus_out      - D- line drive
//   tx_busy         - packet in progress
//   tx_done         - one-cycle completion pulse
module usb_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [7:0] tx_fifo_data,
    input  logic       tx_fifo_empty,
    output logic       get_tx_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE_TICK  = TW'(CLKS_PER_BIT - 2);

`ifdef USB_TX_CRC16_EN
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;

    // Reflected CRC16 (poly 0x8005) update for one LSB-first bit.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        crc_step = (crc[0] ^ b) ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
    endfunction
`else
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP} state_t;
`endif

    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [15:0]     r_shift, w_shift_nxt;
    logic [3:0]      r_left,  w_left_nxt;
    logic [2:0]      r_ones,  w_ones_nxt;
    logic [1:0]      r_eop,   w_eop_nxt;
    logic [3:0]      r_pid,   w_pid_nxt;
    logic            r_line,  w_line_nxt;
    logic            r_pop,   w_pop_nxt;
    logic            r_dp,    w_dp_nxt;
    logic            r_dm,    w_dm_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;
`ifdef USB_TX_CRC16_EN
    logic [15:0]     r_crc,   w_crc_nxt;
`endif

    logic w_bnd, w_pre, w_stuff, w_need_byte;
    logic w_emit, w_bit, w_go_eop;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_shift <= '0;
            r_left  <= '0;
            r_ones  <= '0;
            r_eop   <= '0;
            r_pid   <= '0;
            r_line  <= 1'b1;
            r_pop   <= 1'b0;
            r_dp    <= 1'b1;
            r_dm    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef USB_TX_CRC16_EN
            r_crc   <= 16'hFFFF;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_shift <= w_shift_nxt;
            r_left  <= w_left_nxt;
            r_ones  <= w_ones_nxt;
            r_eop   <= w_eop_nxt;
            r_pid   <= w_pid_nxt;
            r_line  <= w_line_nxt;
            r_pop   <= w_pop_nxt;
            r_dp    <= w_dp_nxt;
            r_dm    <= w_dm_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef USB_TX_CRC16_EN
            r_crc   <= w_crc_nxt;
`endif
        end
    end

    // Next-state: bit timer, field sequencing, stuffing, NRZI and EOP.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_left_nxt  = r_left;
        w_ones_nxt  = r_ones;
        w_eop_nxt   = r_eop;
        w_pid_nxt   = r_pid;
        w_line_nxt  = r_line;
        w_dp_nxt    = r_dp;
        w_dm_nxt    = r_dm;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pop_nxt   = 1'b0;
`ifdef USB_TX_CRC16_EN
        w_crc_nxt   = r_crc;
`endif
        w_emit      = 1'b0;
        w_bit       = 1'b0;
        w_go_eop    = 1'b0;

        w_bnd       = (r_timer == LAST_TICK);
        w_pre       = (r_timer == PRE_TICK);
        w_stuff     = (r_ones == 3'd6);
        // Next line bit is bit 0 of a new payload byte.
        w_need_byte = ((r_state == S_PID) || (r_state == S_DATA)) &&
                      (r_left == 4'd0) && !w_stuff;

        if (r_state == S_IDLE)
            w_timer_nxt = '0;
        else
            w_timer_nxt = w_bnd ? '0 : r_timer + TW'(1);

        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_state_nxt = S_SYNC;
                    w_busy_nxt  = 1'b1;
                    w_pid_nxt   = tx_pid;
                    w_emit      = 1'b1;
                    w_bit       = 1'b0;
                    w_shift_nxt = 16'h0040;
                    w_left_nxt  = 4'd7;
`ifdef USB_TX_CRC16_EN
                    w_crc_nxt   = 16'hFFFF;
`endif
                end
            end
            S_EOP: begin
                // SE0, SE0, then J; done lands on the last cycle of J.
                if (w_pre && (r_eop == 2'd2)) begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
                if (w_bnd) begin
                    if (r_eop == 2'd2) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_eop_nxt = r_eop + 2'd1;
                        if (r_eop == 2'd1) begin
                            w_line_nxt = 1'b1;
                            w_dp_nxt   = 1'b1;
                            w_dm_nxt   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                // Pop one cycle before the boundary so the FWFT head is valid then.
                if (w_pre)
                    w_pop_nxt = w_need_byte && !tx_fifo_empty;
                if (w_bnd) begin
                    if (w_stuff) begin
                        w_emit = 1'b1;
                        w_bit  = 1'b0;
                    end else if (r_left != 4'd0) begin
                        w_emit      = 1'b1;
                        w_bit       = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                        w_left_nxt  = r_left - 4'd1;
`ifdef USB_TX_CRC16_EN
                        if (r_state == S_DATA)
                            w_crc_nxt = crc_step(r_crc, r_shift[0]);
`endif
                    end else begin
                        case (r_state)
                            S_SYNC: begin
                                w_state_nxt = S_PID;
                                w_emit      = 1'b1;
                                w_bit       = r_pid[0];
                                w_shift_nxt = {8'h00, ~r_pid, r_pid} >> 1;
                                w_left_nxt  = 4'd7;
                            end
                            S_PID, S_DATA: begin
                                if (r_pop) begin
                                    w_state_nxt = S_DATA;
                                    w_emit      = 1'b1;
                                    w_bit       = tx_fifo_data[0];
                                    w_shift_nxt = {8'h00, tx_fifo_data} >> 1;
                                    w_left_nxt  = 4'd7;
`ifdef USB_TX_CRC16_EN
                                    w_crc_nxt   = crc_step(r_crc, tx_fifo_data[0]);
                                end else if (r_pid[1:0] == 2'b11) begin
                                    w_state_nxt = S_CRC;
                                    w_emit      = 1'b1;
                                    w_bit       = ~r_crc[0];
                                    w_shift_nxt = {1'b0, ~r_crc[15:1]};
                                    w_left_nxt  = 4'd15;
`endif
                                end else begin
                                    w_go_eop = 1'b1;
                                end
                            end
                            default: w_go_eop = 1'b1;
                        endcase
                    end
                end
            end
        endcase

        if (w_go_eop) begin
            w_state_nxt = S_EOP;
            w_eop_nxt   = 2'd0;
            w_dp_nxt    = 1'b0;
            w_dm_nxt    = 1'b0;
        end

        // NRZI: 0 toggles the line, 1 holds it; stuffed bits are 0s.
        if (w_emit) begin
            w_line_nxt = w_bit ? r_line : ~r_line;
            w_dp_nxt   = w_line_nxt;
            w_dm_nxt   = ~w_line_nxt;
            w_ones_nxt = w_bit ? r_ones + 3'd1 : 3'd0;
        end
    end

    assign get_tx_data = r_pop;
    assign dplus_out   = r_dp;
    assign dminus_out  = r_dm;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;

endmodule
